// File: rtl/fifo_buffer_pkg.sv
// ============================================================================
// Module   : fifo_buffer_pkg
// Purpose  : Shared constants, pointer-width helper and depth check for the
//            fifo_buffer storage element.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_buffer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_DEPTH = 4;

  // Pointer width; never below one bit so that DEPTH=2 still yields a usable
  // index vector.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // True for powers of two of at least 2; pointer wrap relies on this.
  function automatic bit is_pow2(input int unsigned v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// Elaboration-time rejection of unsupported depths.
`ifndef FIFO_BUFFER_CHECK_DEPTH
`define FIFO_BUFFER_CHECK_DEPTH(D) \
  if (!fifo_buffer_pkg::is_pow2(D)) begin : g_depth_check \
    $error("fifo_buffer: DEPTH must be a power of two >= 2"); \
  end
`endif

`default_nettype wire

// File: rtl/fifo_buffer_ptr.sv
// ============================================================================
// Module   : fifo_buffer_ptr
// Purpose  : Wrap-around pointer register with increment enable and
//            synchronous clear. Wraps naturally at 2**W.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_buffer_ptr #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  // Next pointer: clear has priority over advance.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (en_i) begin
      ptr_d = ptr_q + W'(1);
    end
  end

  // Pointer register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

`default_nettype wire

// File: rtl/fifo_buffer.sv
// ============================================================================
// Module   : fifo_buffer
// Purpose  : Synchronous first-word-fall-through FIFO, DEPTH x WIDTH, with
//            valid/ready handshakes, occupancy outputs and synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_buffer
  import fifo_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  `FIFO_BUFFER_CHECK_DEPTH(DEPTH)

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             w_push;
  logic             w_pop;

  // Status flags come from the registered count only.
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign in_ready  = !full && !flush;
  assign out_valid = !empty;
  assign out_data  = mem_q[rd_ptr];

  // A pop during flush is discarded; push is already blocked by in_ready.
  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready && !flush;

  fifo_buffer_ptr #(.W(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (flush),
    .en_i  (w_push),
    .ptr_o (wr_ptr)
  );

  fifo_buffer_ptr #(.W(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (flush),
    .en_i  (w_pop),
    .ptr_o (rd_ptr)
  );

  // Occupancy next state: unchanged when push and pop coincide.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (w_push && !w_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (w_pop && !w_push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Occupancy register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage array; contents are never reset or cleared.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr] <= in_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_buffer.sv
// ============================================================================
// Module   : tb_fifo_buffer
// Purpose  : Self-checking bench for fifo_buffer (WIDTH=8, DEPTH=4) with a
//            queue-based reference model and scoreboard monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_buffer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       count;
  logic             full;
  logic             empty;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the ordered list of words currently held.
  logic [WIDTH-1:0] sb_q[$];

  fifo_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: checks status against the model each cycle, compares popped
  // data with the scoreboard head, then commits the accepted transfers.
  always @(negedge clk) begin
    int  sz;
    bit  m_push;
    bit  m_pop;
    if (!rst_n) begin
      sb_q.delete();
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
    end else begin
      sz     = sb_q.size();
      m_push = in_valid && (sz < DEPTH) && !flush;
      m_pop  = (sz > 0) && out_ready && !flush;
      chk("count", 32'(count), 32'(sz));
      chk("full", 32'(full), 32'(sz == DEPTH));
      chk("empty", 32'(empty), 32'(sz == 0));
      chk("in_ready", 32'(in_ready), 32'((sz < DEPTH) && !flush));
      chk("out_valid", 32'(out_valid), 32'(sz > 0));
      if (m_pop) begin
        chk("out_data", 32'(out_data), 32'(sb_q[0]));
        void'(sb_q.pop_front());
      end
      if (flush) begin
        sb_q.delete();
      end else if (m_push) begin
        sb_q.push_back(in_data);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) cyc();
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    // Fill to full, offer a fifth word, then drain in order.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b0);
      cyc();
    end
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    #1;
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    cyc();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (4) cyc();
    #1;
    chk("drain_empty", 32'(empty), 32'd1);

    // Full with simultaneous offer and pop: pop only, push next cycle.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
      cyc();
    end
    drive(1'b1, 8'hA4, 1'b1, 1'b0);
    cyc();
    #1;
    chk("fullpop_count", 32'(count), 32'd3);
    drive(1'b1, 8'hA4, 1'b0, 1'b0);
    cyc();
    #1;
    chk("fullpop_refill", 32'(count), 32'd4);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (4) cyc();

    // Wrap-around: interleaved push/pop then three more pushes.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
      cyc();
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      cyc();
    end
    for (int i = 3; i < 6; i++) begin
      drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
      cyc();
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (3) cyc();

    // Sustained push+pop at occupancy 2.
    drive(1'b1, 8'h60, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 8'h61, 1'b0, 1'b0);
    cyc();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'(8'h62 + i), 1'b1, 1'b0);
      cyc();
      chk("stream_count", 32'(count), 32'd2);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (2) cyc();

    // Flush with traffic offered on both sides.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'hC1 + i), 1'b0, 1'b0);
      cyc();
    end
    drive(1'b1, 8'hC4, 1'b1, 1'b1);
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    cyc();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    drive(1'b1, 8'hB1, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 8'hB2, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (2) cyc();

    // Asynchronous reset mid-cycle with three entries held.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'hD1 + i), 1'b0, 1'b0);
      cyc();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    chk("pre_areset_count", 32'(count), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("areset_count", 32'(count), 32'd0);
    chk("areset_empty", 32'(empty), 32'd1);
    chk("areset_in_ready", 32'(in_ready), 32'd1);
    chk("areset_out_valid", 32'(out_valid), 32'd0);
    repeat (2) cyc();
    rst_n = 1'b1;

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 2000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 39) == 0));
      cyc();
    end

    drive(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (DEPTH + 2) cyc();
    #1;
    chk("final_empty", 32'(empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_buffer.md
# fifo_buffer

Parametrised, registered successor to the single-bit pass-through buffer cell: a synchronous FIFO of DEPTH words of WIDTH bits with valid/ready handshakes on both sides, occupancy reporting and synchronous flush. Used as the storage element between producer and consumer netlist blocks wherever a plain combinational buffer cannot absorb backpressure or rate mismatch. First-word fall-through: the head entry is presented on the output without a read request.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 4, entry count; power of two, ≥2
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- flush  input  1  synchronous clear of all entries
- in_valid  input  1  producer offers in_data
- in_ready  output  1  FIFO accepts this cycle
- in_data  input  WIDTH  write data
- out_valid  output  1  head entry available
- out_ready  input  1  consumer takes head this cycle
- out_data  output  WIDTH  head entry
- count  output  $clog2(DEPTH+1)  current occupancy
- full  output  1  count == DEPTH
- empty  output  1  count == 0

## Operation
- State: storage array mem[DEPTH], wr_ptr and rd_ptr of $clog2(DEPTH) bits, count register. Pointers wrap modulo DEPTH naturally (power-of-two depth); no explicit compare against DEPTH-1.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = !full & !flush. out_valid = !empty. out_data = mem[rd_ptr] (combinational read of registered storage).
- push: mem[wr_ptr] <= in_data, wr_ptr++.
- pop: rd_ptr++.
- count: +1 on push only, −1 on pop only, unchanged on both or neither.
- Simultaneous push and pop when neither full nor empty: both performed, count unchanged.
- Full: in_ready low, push impossible; pop still allowed. No same-cycle write-through when full.
- Empty: out_valid low, pop impossible; push allowed. No bypass: data written while empty appears next cycle.
- flush high: wr_ptr, rd_ptr, count <= 0 next edge; any pop that cycle is ignored (pointers still cleared); storage contents not cleared (don't-care).
- out_data when empty: undefined; bench must not check it.
- Asynchronous reset: wr_ptr, rd_ptr, count <= 0 immediately on rst_n low, regardless of clk. Mid-transfer reset discards all entries. Storage array not reset.

## Timing
- Reset values: in_ready=1, out_valid=0, count=0, full=0, empty=1, out_data undefined.
- Write-to-read latency: 1 cycle (push at edge N, out_valid high after edge N).
- Pop effect: next entry on out_data after the same edge that consumed the head.
- full, empty, count are decoded from registered count; no combinational path from in_valid/out_ready to them.
- in_ready depends combinationally on flush only (plus registered state); out_valid purely registered.
- Sustained throughput: 1 word/cycle with in_valid and out_ready held high and 0 < count < DEPTH.

## Structure
- Shared package fifo_buffer_pkg: function for pointer width ($clog2 wrapper tolerant of DEPTH=2), default WIDTH/DEPTH constants, parameter-check macro for non-power-of-two DEPTH (elaboration error).
- One sub-module natural: fifo_buffer_ptr, a wrap-around pointer register with enable and synchronous clear, instantiated twice (wr/rd).
- Storage as plain register array; no RAM macro.

## Test plan
- Reset: assert rst_n=0 mid-cycle with 3 entries held -> count=0, empty=1, in_ready=1, out_valid=0 without waiting for a clk edge.
- Fill/drain, WIDTH=8 DEPTH=4: push 0x11,0x22,0x33,0x44 with out_ready=0 -> full=1, in_ready=0, count=4; fifth push 0x55 refused; drain -> outputs 0x11..0x44 in order, empty=1 after fourth pop.
- Wrap-around: push 6 words, popping after each of the first 3 with count≤3 -> all 6 read back in order, pointers wrap past index 3.
- Simultaneous push/pop at count=2 for 10 cycles with incrementing data -> count stays 2, output sequence strictly incrementing, no loss.
- Full with pop: count=4, in_valid=1, out_ready=1 -> pop only, count=3 next cycle; push accepted the cycle after.
- Flush with in_valid=1, out_ready=1, count=3 -> in_ready=0 that cycle, count=0 and empty=1 next cycle, flushed data never reappears.
